// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter: multi-digit modulo-MODULUS up/down counter with clear, checked
// parallel load, wrap or saturate at terminal count, sticky overflow and a combinational
// cascade carry so instances can be chained.
//
// Ports:
//   clk       rising-edge clock
//   rstn      asynchronous active-low reset
//   en        count enable / carry-in from a lower stage
//   up        direction, 1 = increment, 0 = decrement
//   clr       synchronous clear (highest priority)
//   load      synchronous parallel load (below clr)
//   load_val  load value, digit i in bits [4i+3:4i]
//   cnt       current count, digit 0 least significant
//   cout      combinational carry/borrow out, high in the cycle before a terminal step
//   ovf       sticky overflow/underflow flag
//   load_err  one-cycle pulse after a rejected load
module bcd_updown_counter #(
  parameter int unsigned DIGITS   = 2,
  parameter int unsigned MODULUS  = 10,
  parameter int unsigned SATURATE = 0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  en,
  input  logic                  up,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   cnt,
  output logic                  cout,
  output logic                  ovf,
  output logic                  load_err
);

  localparam logic [3:0] MaxDigit = 4'(MODULUS - 1);
  localparam logic [4:0] ModWide  = 5'(MODULUS);

  logic [4*DIGITS-1:0] cnt_q, cnt_d;
  logic [4*DIGITS-1:0] stepped;
  logic                ovf_q, ovf_d;
  logic                load_err_q, load_err_d;
  logic                tc_up, tc_dn, tc;
  logic                load_ok;
  logic                carry;
  logic [3:0]          dig;

  // Terminal-count detection and load validity.
  always_comb begin
    tc_up   = 1'b1;
    tc_dn   = 1'b1;
    load_ok = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      tc_up = tc_up & (cnt_q[4*i +: 4] == MaxDigit);
      tc_dn = tc_dn & (cnt_q[4*i +: 4] == 4'd0);
      if ({1'b0, load_val[4*i +: 4]} >= ModWide) begin
        load_ok = 1'b0;
      end
    end
    tc = up ? tc_up : tc_dn;
  end

  // Ripple a step through the digits: a digit moves only when every lower digit is at
  // its rollover value for the current direction.
  always_comb begin
    stepped = cnt_q;
    carry   = 1'b1;
    dig     = 4'd0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      dig = cnt_q[4*i +: 4];
      if (carry) begin
        if (up) begin
          stepped[4*i +: 4] = (dig == MaxDigit) ? 4'd0 : dig + 4'd1;
          carry             = (dig == MaxDigit);
        end else begin
          stepped[4*i +: 4] = (dig == 4'd0) ? MaxDigit : dig - 4'd1;
          carry             = (dig == 4'd0);
        end
      end
    end
  end

  // Next state: clr > load > en.
  always_comb begin
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    load_err_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (load) begin
      if (load_ok) begin
        cnt_d = load_val;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (en) begin
      if (tc) begin
        ovf_d = 1'b1;
        // Saturating counters hold at the terminal count; wrapping ones take the step.
        if (SATURATE == 0) begin
          cnt_d = stepped;
        end
      end else begin
        cnt_d = stepped;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      load_err_q <= load_err_d;
    end
  end

  assign cnt      = cnt_q;
  assign ovf      = ovf_q;
  assign load_err = load_err_q;
  // Zero-latency so a following stage's en can be driven directly.
  assign cout     = en & tc & ~clr & ~load;

endmodule

// File: tb/tb_bcd_updown_counter.sv
module tb_bcd_updown_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;

  // Main wrapping instance.
  logic       en, up, clr, load;
  logic [7:0] load_val, cnt;
  logic       cout, ovf, load_err;

  // Saturating instance.
  logic       s_en, s_up, s_clr, s_load;
  logic [7:0] s_load_val, s_cnt;
  logic       s_cout, s_ovf, s_load_err;

  // Cascaded pair.
  logic       c_en;
  logic [7:0] lo_cnt, hi_cnt;
  logic       lo_cout, lo_ovf, lo_err, hi_cout, hi_ovf, hi_err;

  int n_checks = 0;
  int n_errors = 0;

  bcd_updown_counter #(.DIGITS(2), .MODULUS(10), .SATURATE(0)) dut (
    .clk(clk), .rstn(rstn), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .cnt(cnt), .cout(cout), .ovf(ovf), .load_err(load_err)
  );

  bcd_updown_counter #(.DIGITS(2), .MODULUS(10), .SATURATE(1)) dut_sat (
    .clk(clk), .rstn(rstn), .en(s_en), .up(s_up), .clr(s_clr), .load(s_load),
    .load_val(s_load_val), .cnt(s_cnt), .cout(s_cout), .ovf(s_ovf), .load_err(s_load_err)
  );

  bcd_updown_counter #(.DIGITS(2), .MODULUS(10), .SATURATE(0)) dut_lo (
    .clk(clk), .rstn(rstn), .en(c_en), .up(1'b1), .clr(1'b0), .load(1'b0),
    .load_val(8'h00), .cnt(lo_cnt), .cout(lo_cout), .ovf(lo_ovf), .load_err(lo_err)
  );

  bcd_updown_counter #(.DIGITS(2), .MODULUS(10), .SATURATE(0)) dut_hi (
    .clk(clk), .rstn(rstn), .en(lo_cout), .up(1'b1), .clr(1'b0), .load(1'b0),
    .load_val(8'h00), .cnt(hi_cnt), .cout(hi_cout), .ovf(hi_ovf), .load_err(hi_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] bcd(input int k);
    return {4'(k / 10), 4'(k % 10)};
  endfunction

  function automatic logic digits_ok(input logic [7:0] v);
    return (v[3:0] < 4'd10) && (v[7:4] < 4'd10);
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      check("digit_range", 32'(digits_ok(cnt) & digits_ok(s_cnt) & digits_ok(lo_cnt)
                               & digits_ok(hi_cnt)), 32'd1);
    end
  end

  initial begin
    rstn = 1'b0;
    en = 1'b1; up = 1'b0; clr = 1'b0; load = 1'b0; load_val = 8'h00;
    s_en = 1'b0; s_up = 1'b1; s_clr = 1'b0; s_load = 1'b0; s_load_val = 8'h00;
    c_en = 1'b0;

    // Reset state; counting down from zero is terminal, so cout is high.
    #1;
    check("rst_cout_dn", 32'(cout), 32'd1);
    check("rst_cnt", 32'(cnt), 32'h00);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_load_err", 32'(load_err), 32'd0);

    @(negedge clk);
    rstn = 1'b1;
    up = 1'b1;

    // Wrap up through 00..99.
    for (int k = 0; k < 100; k++) begin
      #1;
      check("up_cnt", 32'(cnt), 32'(bcd(k)));
      check("up_cout", 32'(cout), 32'(k == 99));
      if (k == 99) check("up_ovf_before_wrap", 32'(ovf), 32'd0);
      tick();
    end
    check("up_wrap_cnt", 32'(cnt), 32'h00);
    check("up_wrap_ovf", 32'(ovf), 32'd1);

    en = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_ovf", 32'(ovf), 32'd0);

    // Down count with borrow.
    load = 1'b1; load_val = 8'h10;
    tick();
    load = 1'b0;
    check("load10", 32'(cnt), 32'h10);
    en = 1'b1; up = 1'b0;
    for (int k = 10; k >= 0; k--) begin
      #1;
      check("dn_cnt", 32'(cnt), 32'(bcd(k)));
      check("dn_cout", 32'(cout), 32'(k == 0));
      tick();
    end
    check("dn_wrap_cnt", 32'(cnt), 32'h99);
    check("dn_wrap_ovf", 32'(ovf), 32'd1);

    // Direction flips with no dead cycle.
    up = 1'b1;
    #1;
    check("flip_cout", 32'(cout), 32'd1);
    tick();
    check("flip_cnt", 32'(cnt), 32'h00);
    en = 1'b0;

    // Load validation.
    load = 1'b1; load_val = 8'h3A;
    tick();
    load = 1'b0;
    check("bad_load_hold", 32'(cnt), 32'h00);
    check("bad_load_err", 32'(load_err), 32'd1);
    tick();
    check("bad_load_err_pulse", 32'(load_err), 32'd0);
    load = 1'b1; load_val = 8'h37;
    tick();
    load = 1'b0;
    check("good_load_cnt", 32'(cnt), 32'h37);
    check("good_load_err", 32'(load_err), 32'd0);
    check("load_keeps_ovf", 32'(ovf), 32'd1);

    // Priority: clr beats load and en; cout masked even at terminal count.
    load = 1'b1; load_val = 8'h99;
    tick();
    check("load99", 32'(cnt), 32'h99);
    clr = 1'b1; load = 1'b1; load_val = 8'h55; en = 1'b1; up = 1'b1;
    #1;
    check("prio_cout", 32'(cout), 32'd0);
    tick();
    clr = 1'b0;
    check("prio_clr_cnt", 32'(cnt), 32'h00);
    check("prio_clr_ovf", 32'(ovf), 32'd0);
    tick();
    load = 1'b0; en = 1'b0;
    check("prio_load_cnt", 32'(cnt), 32'h55);

    // Saturating instance.
    s_load = 1'b1; s_load_val = 8'h98;
    tick();
    s_load = 1'b0; s_en = 1'b1; s_up = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("sat_cnt", 32'(s_cnt), (i == 0) ? 32'h98 : 32'h99);
      check("sat_cout", 32'(s_cout), 32'(i != 0));
      check("sat_ovf", 32'(s_ovf), 32'(i >= 2));
      tick();
    end
    check("sat_final_cnt", 32'(s_cnt), 32'h99);
    check("sat_final_ovf", 32'(s_ovf), 32'd1);
    s_en = 1'b0;

    // Cascade two instances for 150 enabled cycles.
    c_en = 1'b1;
    for (int k = 0; k < 150; k++) begin
      if (k == 99) begin
        #1;
        check("casc_lo_cout", 32'(lo_cout), 32'd1);
        check("casc_hi_before", 32'(hi_cnt), 32'h00);
      end
      tick();
    end
    c_en = 1'b0;
    check("casc_total", 32'({hi_cnt, lo_cnt}), 32'h0150);

    // Asynchronous reset between edges.
    #2;
    rstn = 1'b0;
    #1;
    check("async_cnt", 32'(cnt), 32'h00);
    check("async_sat_cnt", 32'(s_cnt), 32'h00);
    check("async_sat_ovf", 32'(s_ovf), 32'd0);
    check("async_casc", 32'({hi_cnt, lo_cnt}), 32'h0000);
    @(negedge clk);
    rstn = 1'b1; en = 1'b1; up = 1'b1;
    tick();
    en = 1'b0;
    check("resume_cnt", 32'(cnt), 32'h01);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
